clock_gen_multi: RTL and testbench
==================================

# clock_gen_multi

Synthesizable multi-channel clock generator deriving NUM_CH independent divided clocks from the system clock. Each channel has its own period, high time and bounded random jitter. Each channel also reports activity and configuration-error status, and issues a period-start strobe. Configuration changes and enable/disable take effect only at period boundaries, so every output is glitch-free. The block drives the stimulus clocks used by the clock VIP agents and DUT clock inputs.

## Interface
- NUM_CH, default 4: number of independent clock channels.
- CNT_W, default 16: width of the period and high-time fields, in clk cycles.
- JIT_W, default 8: width of the jitter field; must be ≤ 16.
- SEED, default 16'hACE1: LFSR base seed; channel i resets to SEED ^ i, forced to 16'h0001 if that is zero.
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  NUM_CH  per-channel run request.
- period_cyc  in  NUM_CH×CNT_W  clock period in clk cycles.
- high_cyc  in  NUM_CH×CNT_W  high-phase length in clk cycles.
- jitter_cyc  in  NUM_CH×JIT_W  maximum extra low-phase cycles per period (peak jitter).
- clock_out  out  NUM_CH  generated clocks, registered.
- clock_active  out  NUM_CH  channel is mid-period (not IDLE).
- config_error  out  NUM_CH  registered flag: current config is illegal.
- period_start  out  NUM_CH  one-cycle pulse coincident with each clock_out rising edge.

## Operation
- Reset value of every output is 0. Each channel resets to IDLE, its counter to 0 and its LFSR to its seed.
- Legal config: period_cyc ≥ 2, high_cyc ≥ 1 and high_cyc < period_cyc. Otherwise the config is illegal.
- config_error is registered every cycle from the live inputs, independent of enable and state.
- Per-channel FSM, with states IDLE, HIGH and LOW:
  - IDLE → HIGH when enable=1 and the config is legal; otherwise the channel stays in IDLE with clock_out=0.
  - HIGH lasts exactly high_s cycles, then the channel moves to LOW.
  - LOW lasts exactly (period_s − high_s + j) cycles.
  - At the end of LOW: if enable=1 and the config is legal, the channel goes to HIGH (new period); otherwise it goes to IDLE.
- Shadowing:
  - period_s, high_s and j are latched on each IDLE→HIGH or LOW→HIGH transition.
  - Input changes mid-period have no effect until the next boundary.
- Jitter:
  - Let r = lfsr[JIT_W-1:0].
  - j = (r > jitter_cyc) ? jitter_cyc : r.
  - jitter_cyc = 0 gives an exact period.
  - Jitter only extends the low phase; the high phase is never jittered.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances exactly once per period start, after j has been sampled.
- Disable mid-period: the current period completes (HIGH and LOW, jitter included), then the channel enters IDLE. There is never a truncated pulse.
- Illegal config at a boundary with enable=1: the channel enters IDLE, and config_error=1 (already asserted from the prior cycle).
- clock_active = (state ≠ IDLE).
- Width rule: the low-phase length is computed in CNT_W+1 bits, so period_s − high_s + j cannot overflow.

## Timing
- Enable latency: enable sampled 1 at edge N with legal config → clock_out=1, period_start=1 and clock_active=1 after edge N+1. This gives one cycle of latency.
- clock_out high for high_s cycles, then low for period_s − high_s + j cycles.
- Back-to-back periods have no idle gap.
- config_error is valid one cycle after an input change.
- Asynchronous reset mid-period forces all outputs to 0 immediately. After release, the first rise requires a new enable sample.
- Channels are fully independent; simultaneous boundary events on different channels do not interact.

## Structure
- Package clock_gen_pkg holds:
  - the state enum (ST_IDLE, ST_HIGH, ST_LOW);
  - the LFSR mask constant LFSR_POLY = 16'hB400;
  - the function cfg_legal(period, high).
- Sub-module clock_gen_chan implements one channel (FSM, counter, shadow registers, LFSR).
- The top level instantiates clock_gen_chan NUM_CH times via generate, passing seed SEED ^ i.

## Test plan
- Ch0 period=4, high=2, jitter=0, enable at cycle 10:
  - clock_out is 0 through cycle 10, then follows the pattern 1100 repeating from cycle 11;
  - period_start pulses every 4 cycles.
- Ch1 period=5, high=4, with Ch2 period=2, high=1 concurrently:
  - Ch1 duty is 80% and Ch2 toggles every cycle;
  - neither channel disturbs the other.
- Ch0 period=4, high=4, enable=1:
  - config_error=1 one cycle later;
  - clock_out and clock_active stay 0;
  - fixing high=1 starts the clock one cycle after config_error clears.
- Ch0 running at period=6, high=3; deassert enable in the 2nd HIGH cycle:
  - the full 3-high/3-low period completes, then clock_active=0;
  - no truncated pulse occurs.
- Ch0 period 4 → 8 written mid-HIGH: the current period remains 4 cycles and the next period is 8.
- Ch0 period=4, high=2, jitter=3 over 1000 periods:
  - every low phase is in [2,5];
  - all four lengths are observed;
  - the high phase is always exactly 2.
  - Assert rst_n=0 mid-LOW: all outputs are 0 within the same cycle.

Source files
------------

// File: rtl/clock_gen_pkg.sv
// Shared types and helpers for the multi-channel clock generator.
// Pure declarations: no latency, no backpressure.
package clock_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Callers zero-extend their CNT_W-wide fields into 32 bits.
  function automatic logic cfg_legal(input logic [31:0] period, input logic [31:0] high);
    return (period >= 32'd2) && (high >= 32'd1) && (high < period);
  endfunction

  // One step of the right-shifting Galois LFSR for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/clock_gen_chan.sv
// One divided-clock channel: IDLE/HIGH/LOW FSM, shadowed period config, LFSR jitter on the low phase.
// Outputs are one cycle behind the FSM state; no backpressure, config is only sampled at period boundaries.
module clock_gen_chan
  import clock_gen_pkg::*;
#(
  parameter int          CNT_W = 16,
  parameter int          JIT_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period_cyc,
  input  logic [CNT_W-1:0] high_cyc,
  input  logic [JIT_W-1:0] jitter_cyc,
  output logic             clock_out,
  output logic             clock_active,
  output logic             config_error,
  output logic             period_start
);

  localparam int LW = CNT_W + 1;

  state_t          state;
  state_t          state_nxt;
  logic [LW-1:0]   cnt;
  logic [LW-1:0]   low_s;
  logic [15:0]     lfsr;
  logic            start_flag;

  logic            legal;
  logic            cnt_done;
  logic            go_high;
  logic [JIT_W-1:0] rnd;
  logic [JIT_W-1:0] jit;
  logic [LW-1:0]   low_len;

  logic            clock_nxt;
  logic            active_nxt;
  logic            start_nxt;

  assign legal    = cfg_legal(32'(period_cyc), 32'(high_cyc));
  assign cnt_done = (cnt == '0);
  assign rnd      = lfsr[JIT_W-1:0];
  assign jit      = (rnd > jitter_cyc) ? jitter_cyc : rnd;
  // Extra bit keeps period - high + jitter from wrapping.
  assign low_len  = LW'(period_cyc) - LW'(high_cyc) + LW'(jit);
  assign go_high  = (state_nxt == ST_HIGH) && (state != ST_HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable && legal) state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        if (cnt_done) state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (cnt_done) state_nxt = (enable && legal) ? ST_HIGH : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    clock_nxt  = (state == ST_HIGH);
    active_nxt = (state != ST_IDLE);
    start_nxt  = start_flag;
  end

  // Down-counter loaded with (phase length - 1); config and jitter are captured only on entry to HIGH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      low_s      <= '0;
      lfsr       <= SEED;
      start_flag <= 1'b0;
    end else begin
      start_flag <= go_high;
      if (go_high) begin
        cnt   <= LW'(high_cyc) - LW'(1);
        low_s <= low_len;
        lfsr  <= lfsr_step(lfsr);
      end else if ((state == ST_HIGH) && cnt_done) begin
        cnt <= low_s - LW'(1);
      end else if (!cnt_done) begin
        cnt <= cnt - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clock_out    <= 1'b0;
      clock_active <= 1'b0;
      period_start <= 1'b0;
      config_error <= 1'b0;
    end else begin
      clock_out    <= clock_nxt;
      clock_active <= active_nxt;
      period_start <= start_nxt;
      config_error <= !legal;
    end
  end

endmodule

// File: rtl/clock_gen_multi.sv
// NUM_CH independent glitch-free divided clocks with per-channel period, high time and low-phase jitter.
// One cycle from enable sample to first rising clock_out; no backpressure, changes apply at period boundaries.
module clock_gen_multi
  import clock_gen_pkg::*;
#(
  parameter int          NUM_CH = 4,
  parameter int          CNT_W  = 16,
  parameter int          JIT_W  = 8,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*CNT_W-1:0] period_cyc,
  input  logic [NUM_CH*CNT_W-1:0] high_cyc,
  input  logic [NUM_CH*JIT_W-1:0] jitter_cyc,
  output logic [NUM_CH-1:0]       clock_out,
  output logic [NUM_CH-1:0]       clock_active,
  output logic [NUM_CH-1:0]       config_error,
  output logic [NUM_CH-1:0]       period_start
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] RAW_SEED = SEED ^ 16'(i);
    localparam logic [15:0] CH_SEED  = (RAW_SEED == 16'h0000) ? 16'h0001 : RAW_SEED;

    clock_gen_chan #(
      .CNT_W (CNT_W),
      .JIT_W (JIT_W),
      .SEED  (CH_SEED)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable[i]),
      .period_cyc   (period_cyc[i*CNT_W +: CNT_W]),
      .high_cyc     (high_cyc[i*CNT_W +: CNT_W]),
      .jitter_cyc   (jitter_cyc[i*JIT_W +: JIT_W]),
      .clock_out    (clock_out[i]),
      .clock_active (clock_active[i]),
      .config_error (config_error[i]),
      .period_start (period_start[i])
    );
  end

endmodule

// File: tb/tb_clock_gen_multi.sv
// Scoreboard bench: a period-level model queues the expected per-cycle waveform of every channel,
// and a negedge monitor pops and compares it against the DUT outputs.
module tb_clock_gen_multi;

  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 16;
  localparam int          JIT_W  = 8;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH*CNT_W-1:0] period_cyc;
  logic [NUM_CH*CNT_W-1:0] high_cyc;
  logic [NUM_CH*JIT_W-1:0] jitter_cyc;
  logic [NUM_CH-1:0]       clock_out;
  logic [NUM_CH-1:0]       clock_active;
  logic [NUM_CH-1:0]       config_error;
  logic [NUM_CH-1:0]       period_start;

  clock_gen_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .JIT_W  (JIT_W),
    .SEED   (SEED)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .period_cyc   (period_cyc),
    .high_cyc     (high_cyc),
    .jitter_cyc   (jitter_cyc),
    .clock_out    (clock_out),
    .clock_active (clock_active),
    .config_error (config_error),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit ck;
    bit st;
    bit act;
  } exp_t;

  exp_t              exp_q[NUM_CH][$];
  bit [NUM_CH-1:0]   err_q[$];
  logic [15:0]       m_lfsr[NUM_CH];

  int per[NUM_CH];
  int hi[NUM_CH];
  int jit[NUM_CH];
  bit en[NUM_CH];

  int vectors     = 0;
  int miscompares = 0;
  bit run         = 1'b0;

  bit       jit_meas   = 1'b0;
  int       jit_periods = 0;
  int       low_run    = 0;
  bit [3:0] low_seen   = 4'b0;

  task automatic check(input string name, input int ch, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s ch%0d at %0t: got %0d, expected %0d", name, ch, $time, got, want);
    end
  endtask

  task automatic apply();
    for (int c = 0; c < NUM_CH; c++) begin
      enable[c]                      = en[c];
      period_cyc[c*CNT_W +: CNT_W]   = CNT_W'(per[c]);
      high_cyc[c*CNT_W +: CNT_W]     = CNT_W'(hi[c]);
      jitter_cyc[c*JIT_W +: JIT_W]   = JIT_W'(jit[c]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic bit legal_ref(input int p, input int h);
    return (p >= 2) && (h >= 1) && (h < p);
  endfunction

  // Reference model: at each edge, a channel whose queued waveform is about to run out
  // decides its next period from the live inputs and appends it cycle by cycle.
  always @(posedge clk) begin
    bit [NUM_CH-1:0] err;
    int p, h, jt, r, jj, low_len;
    bit ok;
    if (run) begin
      for (int c = 0; c < NUM_CH; c++) begin
        p  = int'(period_cyc[c*CNT_W +: CNT_W]);
        h  = int'(high_cyc[c*CNT_W +: CNT_W]);
        jt = int'(jitter_cyc[c*JIT_W +: JIT_W]);
        ok = legal_ref(p, h);
        err[c] = !ok;
        if (exp_q[c].size() == 1) begin
          if (enable[c] && ok) begin
            r  = int'(m_lfsr[c] % 16'(1 << JIT_W));
            jj = (r > jt) ? jt : r;
            if (m_lfsr[c] % 2 == 1) m_lfsr[c] = (m_lfsr[c] / 2) ^ 16'hB400;
            else                    m_lfsr[c] = m_lfsr[c] / 2;
            low_len = p - h + jj;
            for (int k = 0; k < h; k++)       exp_q[c].push_back('{ck: 1'b1, st: (k == 0), act: 1'b1});
            for (int k = 0; k < low_len; k++) exp_q[c].push_back('{ck: 1'b0, st: 1'b0, act: 1'b1});
          end else begin
            exp_q[c].push_back('{ck: 1'b0, st: 1'b0, act: 1'b0});
          end
        end
      end
      err_q.push_back(err);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit [NUM_CH-1:0] ce;
    if (run) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (exp_q[c].size() == 0) begin
          check("expected_queue_empty", c, 0, 1);
        end else begin
          e = exp_q[c].pop_front();
          check("clock_out",    c, int'(clock_out[c]),    int'(e.ck));
          check("period_start", c, int'(period_start[c]), int'(e.st));
          check("clock_active", c, int'(clock_active[c]), int'(e.act));
        end
      end
      if (err_q.size() > 0) begin
        ce = err_q.pop_front();
        for (int c = 0; c < NUM_CH; c++) check("config_error", c, int'(config_error[c]), int'(ce[c]));
      end
      if (clock_out[0]) begin
        if (jit_meas && low_run >= 2 && low_run <= 5) low_seen[low_run-2] = 1'b1;
        low_run = 0;
      end else if (clock_active[0]) begin
        low_run++;
      end
      if (jit_meas && period_start[0]) jit_periods++;
    end
  end

  task automatic rand_cfg(input int c);
    per[c] = $urandom_range(2, 10);
    hi[c]  = $urandom_range(1, per[c] - 1);
    if ($urandom_range(0, 7) == 0) begin
      per[c] = $urandom_range(0, 12);
      hi[c]  = $urandom_range(0, 12);
    end
    jit[c] = $urandom_range(0, 4);
    en[c]  = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_start(input int c);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step();
      if (period_start[c]) seen = 1'b1;
    end
    check("wait_period_start", c, int'(seen), 1);
  endtask

  initial begin
    bit found;
    for (int c = 0; c < NUM_CH; c++) begin
      en[c] = 1'b0; per[c] = 4; hi[c] = 2; jit[c] = 0;
    end
    apply();
    repeat (3) step();
    for (int c = 0; c < NUM_CH; c++) begin
      check("reset_clock_out",    c, int'(clock_out[c]),    0);
      check("reset_clock_active", c, int'(clock_active[c]), 0);
      check("reset_period_start", c, int'(period_start[c]), 0);
      check("reset_config_error", c, int'(config_error[c]), 0);
    end
    step();
    for (int c = 0; c < NUM_CH; c++) begin
      m_lfsr[c] = SEED ^ 16'(c);
      if (m_lfsr[c] == 16'h0000) m_lfsr[c] = 16'h0001;
      exp_q[c].push_back('{ck: 1'b0, st: 1'b0, act: 1'b0});
    end
    rst_n = 1'b1;
    run   = 1'b1;

    // Ch0 4/2 with no jitter, enabled after a quiet stretch.
    repeat (9) step();
    en[0] = 1'b1; apply();
    repeat (40) step();

    // Ch1 at 80% duty and ch2 toggling every cycle side by side.
    en[0] = 1'b0;
    per[1] = 5; hi[1] = 4; en[1] = 1'b1;
    per[2] = 2; hi[2] = 1; en[2] = 1'b1;
    apply();
    repeat (40) step();

    // Illegal high == period, then repaired.
    en[1] = 1'b0; en[2] = 1'b0;
    per[0] = 4; hi[0] = 4; en[0] = 1'b1;
    apply();
    repeat (12) step();
    hi[0] = 1; apply();
    repeat (20) step();

    // 6/3 running, disabled in the second high cycle.
    per[0] = 6; hi[0] = 3; apply();
    repeat (8) step();
    wait_start(0);
    step();
    en[0] = 1'b0; apply();
    repeat (15) step();

    // Period 4 -> 8 written during the high phase.
    per[0] = 4; hi[0] = 2; en[0] = 1'b1; apply();
    repeat (6) step();
    wait_start(0);
    per[0] = 8; apply();
    repeat (30) step();

    // Random reconfiguration of all channels.
    repeat (3000) begin
      step();
      for (int c = 0; c < NUM_CH; c++) if ($urandom_range(0, 39) == 0) rand_cfg(c);
      apply();
    end

    // Ch0 4/2 with up to 3 cycles of jitter on the low phase.
    per[0] = 4; hi[0] = 2; jit[0] = 3; en[0] = 1'b1; apply();
    repeat (12) step();
    jit_meas = 1'b1;
    for (int k = 0; k < 25000 && !(jit_periods >= 1000 && low_seen == 4'b1111); k++) step();
    jit_meas = 1'b0;
    check("jitter_periods_reached", 0, int'(jit_periods >= 1000), 1);
    check("jitter_low_lengths_seen", 0, int'(low_seen), 15);

    // Asynchronous reset in the middle of a low phase.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (!clock_out[0] && clock_active[0] && !period_start[0]) found = 1'b1;
    end
    check("wait_mid_low", 0, int'(found), 1);
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      check("async_rst_clock_out",    c, int'(clock_out[c]),    0);
      check("async_rst_clock_active", c, int'(clock_active[c]), 0);
      check("async_rst_period_start", c, int'(period_start[c]), 0);
      check("async_rst_config_error", c, int'(config_error[c]), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
